grid_scanout: RTL

- Reader end of the cell array: consumes the flattened state vector that all cells drive.
- On each generation tick, snapshots the whole grid.
- Streams the snapshot one cell per transfer over a valid/ready interface, with row/column coordinates and frame markers.
- Feeds the display/UART back-end; runs independently of how long the consumer stalls.

---
 rtl/gol_pkg.sv | 18 +
 rtl/grid_scan_counter.sv | 37 +++
 rtl/grid_scanout.sv | 87 ++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared grid constants, scan FSM encoding and cell bit-index helper
package gol_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cell (r,c) lives at bit r*cols+c of the flattened grid vector
    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c, input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// grid_scan_counter: row-major row/col scan counter with wrap and end-of-row/frame flags
module grid_scan_counter
    import gol_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          eol,
    output logic          eof
);

    assign eol = col == CW'(COLS - 1);
    assign eof = eol && row == RW'(ROWS - 1);

    // Advance column each enable; a column wrap bumps the row, the last cell wraps to (0,0)
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            col <= eol ? '0 : col + CW'(1);
            if (eol) row <= eof ? '0 : row + RW'(1);
        end
    end

endmodule

// File: rtl/grid_scanout.sv
// grid_scanout: snapshots the cell grid on a generation tick and streams it cell by cell
module grid_scanout
    import gol_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [ROWS*COLS-1:0] grid_state,
    input  logic                 gen_tick,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_cell,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic [7:0]           overrun_count
);

    localparam int IW = $clog2(ROWS * COLS);

    state_t               state, state_nx;
    logic [ROWS*COLS-1:0] snapshot;
    logic [IW-1:0]        idx;
    logic                 capture, xfer, eol, eof;

    grid_scan_counter #(.ROWS(ROWS), .COLS(COLS)) u_scan (
        .Clk (Clk),
        .Rst (Rst),
        .clr (capture),
        .en  (xfer),
        .row (out_row),
        .col (out_col),
        .eol (eol),
        .eof (eof)
    );

    assign out_valid  = state == SEND;
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;
    assign xfer       = out_valid && out_ready;
    assign idx        = IW'(cell_idx(32'(out_row), 32'(out_col), COLS));
    assign out_cell   = out_valid && snapshot[idx];
    assign out_sof    = out_valid && out_row == '0 && out_col == '0;
    assign out_eol    = out_valid && eol;
    assign out_eof    = out_valid && eof;

    // Next state: capture from IDLE on a tick, finish after the last accepted cell, DONE lasts one cycle
    always_comb begin
        capture  = state == IDLE && gen_tick;
        state_nx = capture              ? SEND :
                   (xfer && eof)        ? DONE :
                   (state == DONE)      ? IDLE : state;
    end

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Snapshot is only loaded from IDLE, so it stays frozen for the whole frame
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)         snapshot <= '0;
        else if (capture) snapshot <= grid_state;
    end

    // Frame counter wraps; overrun counter saturates on ticks that arrive while busy
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            if (state == DONE) frame_count <= frame_count + 16'd1;
            if (gen_tick && busy && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end
    end

endmodule
